instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Parametrised successor of the single-register fetch stage: generates the I-cache word address,
//  pre-decodes each returned instruction and pushes it into a QUEUE_DEPTH-entry fetch queue.
//  The queue decouples the cache from decode stalls. Branch redirects flush the queue.
//  Sits between the I-cache and the decode stage.
// PARAMETERS
//  ADDR_WIDTH    32           byte-address width; PC is held as word address [ADDR_WIDTH-1:2]
//  QUEUE_DEPTH   4            fetch queue entries; power of two, >= 2
//  RESET_VECTOR  32'h0000_0000 byte address loaded into PC on reset; bits [1:0] ignored
// PORTS
//  clk_i              in   1             clock, rising edge
//  rst_i              in   1             reset, asynchronous, active-high
//  cache_address_o    out  ADDR_WIDTH-2  word address of current fetch (= PC register)
//  cache_req_o        out  1             fetch request; 1 when queue can accept and no redirect
//  cache_data_i       in   32            instruction word for cache_address_o, same cycle
//  cache_blocking_n_i in   1             1 = cache_data_i valid this cycle (hit); 0 = miss/busy
//  stall_i            in   1             decode not ready; head entry is held
//  branching_i        in   1             redirect request from execute
//  branch_target_i    in   ADDR_WIDTH-2  redirect word address
//  valid_o            out  1             queue head valid
//  pc_o               out  ADDR_WIDTH-2  head PC
//  instr_o            out  32            head instruction
//  branch_jump_op_o   out  2             head pre-decode branch/jump op (00 = none)
//  imm_src_o          out  3             head pre-decode immediate select
//  level_o            out  clog2(D)+1    queue occupancy, 0..QUEUE_DEPTH
// BEHAVIOUR
//  Reset (async): PC <= RESET_VECTOR[ADDR_WIDTH-1:2]; queue empty; valid_o=0, level_o=0,
//   branch_jump_op_o=00, imm_src_o=000, pc_o=0, instr_o=0. Outputs never carry X.
//  pop  = valid_o & ~stall_i.
//  push = cache_req_o & cache_blocking_n_i; cache_req_o = ~branching_i & (level_o<D | pop).
//  On push: entry {PC, cache_data_i, quick-decode(cache_data_i[6:2])} written at tail;
//   PC <= PC+1 (word), wraps modulo 2^(ADDR_WIDTH-2); carry discarded.
//  Miss (cache_blocking_n_i=0): no push, PC held, cache_address_o stable until hit.
//  Full and no pop: cache_req_o=0, PC held. Full with pop: push and pop same cycle, level unchanged.
//  Empty: valid_o=0; pop ignored. Push into empty queue: valid_o=1 the next cycle (1-cycle latency
//   from cache hit to decode visibility); no combinational bypass.
//  Redirect (branching_i=1): highest priority, independent of stall_i. Next edge: PC <= branch_target_i,
//   queue flushed (level 0, valid_o=0), any same-cycle push discarded; fetch resumes from target
//   the cycle after. Pop in the redirect cycle still consumes head (decode owns flush of its copy).
//  Head outputs are driven from queue storage registers; when empty they read as zeros.
//  Pointers: head/tail are clog2(D) bits and wrap naturally; level counter distinguishes full/empty.
//  Reset asserted mid-operation: all state returns to reset values immediately, no pending push.
// STRUCTURE
//  Shared package: BRANCH_JUMP_NOP (2'b00), IMM_SRC_NOP (3'b000), fetch-entry field widths.
//  Sub-modules: existing quick_decoder (combinational pre-decode); new fetch_queue
//   (parametrised sync FIFO, width ADDR_WIDTH-2+37, depth QUEUE_DEPTH, async reset, flush input).
//  PC increment reuses existing increment module with DATA_WIDTH = ADDR_WIDTH-2.
// TESTING
//  1 Reset: assert rst_i between edges -> all outputs zero immediately; cache_address_o = RESET_VECTOR>>2.
//  2 Streaming: hits every cycle, stall_i=0 -> valid_o from cycle 2, pc_o 0,1,2,... one per cycle, level_o<=1.
//  3 Miss: cache_blocking_n_i=0 for 3 cycles at PC=5 -> cache_address_o held at 5, no push, resumes at 6.
//  4 Back-pressure: stall_i=1, D=4 -> level_o reaches 4, cache_req_o=0, PC frozen; release -> no loss/dup.
//  5 Redirect: queue holds 3 entries, branching_i=1, target=0x40 -> next cycle valid_o=0, level_o=0,
//   cache_address_o=0x40; first pc_o after is 0x40; also with stall_i=1 and full queue simultaneously.
//  6 Wrap: ADDR_WIDTH=8, PC=6'h3F hit -> next PC=0; entry pc_o=0x3F then 0x00.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the fetch unit: pre-decode encodings and entry widths.
package instruction_fetch_unit_pkg;
    localparam int INSTR_W = 32;
    localparam int BJ_W    = 2;
    localparam int IMM_W   = 3;
    localparam int META_W  = INSTR_W + BJ_W + IMM_W;  // entry bits beyond the PC

    // Branch/jump pre-decode op
    localparam logic [BJ_W-1:0] BRANCH_JUMP_NOP = 2'b00;
    localparam logic [BJ_W-1:0] BJ_BRANCH       = 2'b01;
    localparam logic [BJ_W-1:0] BJ_JAL          = 2'b10;
    localparam logic [BJ_W-1:0] BJ_JALR         = 2'b11;

    // Immediate format select
    localparam logic [IMM_W-1:0] IMM_SRC_NOP = 3'b000;
    localparam logic [IMM_W-1:0] IMM_SRC_I   = 3'b001;
    localparam logic [IMM_W-1:0] IMM_SRC_S   = 3'b010;
    localparam logic [IMM_W-1:0] IMM_SRC_B   = 3'b011;
    localparam logic [IMM_W-1:0] IMM_SRC_U   = 3'b100;
    localparam logic [IMM_W-1:0] IMM_SRC_J   = 3'b101;

    typedef struct packed {
        logic [BJ_W-1:0]  bj_op;
        logic [IMM_W-1:0] imm_src;
    } predecode_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head data reads as zero when empty.
module fetch_queue #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [LW-1:0]    level_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    // Pop on empty is ignored; push on full only when a pop frees the slot
    assign do_pop  = pop_i & (level_q != '0);
    assign do_push = push_i & ((level_q < LW'(DEPTH)) | do_pop);

    // Storage, pointers and occupancy; flush drops contents and any same-cycle push
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= wdata_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (do_pop) head_q <= head_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: ;
            endcase
        end
    end

    assign valid_o = (level_q != '0);
    assign level_o = level_q;
    assign rdata_o = valid_o ? mem_q[head_q] : '0;
endmodule

// File: rtl/increment.sv
// Unsigned +1 with wrap; carry out is dropped.
module increment #(
    parameter int DATA_WIDTH = 30
) (
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic [DATA_WIDTH-1:0] out_o
);
    assign out_o = in_i + DATA_WIDTH'(1);
endmodule

// File: rtl/quick_decoder.sv
// Combinational pre-decode of the RV32 major opcode (instr[6:2]).
module quick_decoder
    import instruction_fetch_unit_pkg::*;
(
    input  logic [4:0]  opcode_i,
    output predecode_t  pd_o
);
    // Map major opcode to branch/jump class and immediate format
    always_comb begin
        pd_o.bj_op   = BRANCH_JUMP_NOP;
        pd_o.imm_src = IMM_SRC_NOP;
        case (opcode_i)
            5'b11000: begin pd_o.bj_op = BJ_BRANCH; pd_o.imm_src = IMM_SRC_B; end
            5'b11011: begin pd_o.bj_op = BJ_JAL;    pd_o.imm_src = IMM_SRC_J; end
            5'b11001: begin pd_o.bj_op = BJ_JALR;   pd_o.imm_src = IMM_SRC_I; end
            5'b00000,
            5'b00100: pd_o.imm_src = IMM_SRC_I;   // load, op-imm
            5'b01000: pd_o.imm_src = IMM_SRC_S;   // store
            5'b01101,
            5'b00101: pd_o.imm_src = IMM_SRC_U;   // lui, auipc
            default:  ;
        endcase
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC generation, I-cache request, pre-decode and fetch queue.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          QUEUE_DEPTH  = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    localparam int AW = ADDR_WIDTH - 2,
    localparam int LW = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [AW-1:0]     cache_address_o,
    output logic              cache_req_o,
    input  logic [INSTR_W-1:0] cache_data_i,
    input  logic              cache_blocking_n_i,
    input  logic              stall_i,
    input  logic              branching_i,
    input  logic [AW-1:0]     branch_target_i,
    output logic              valid_o,
    output logic [AW-1:0]     pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [BJ_W-1:0]   branch_jump_op_o,
    output logic [IMM_W-1:0]  imm_src_o,
    output logic [LW-1:0]     level_o
);
    localparam int EW = AW + META_W;

    logic [AW-1:0] pc_q, pc_d, pc_inc;
    logic          pop, push;
    predecode_t    pd;
    logic [EW-1:0] wentry, rentry;

    assign pop         = valid_o & ~stall_i;
    assign cache_req_o = ~branching_i & ((level_o < LW'(QUEUE_DEPTH)) | pop);
    assign push        = cache_req_o & cache_blocking_n_i;

    quick_decoder u_qdec (
        .opcode_i (cache_data_i[6:2]),
        .pd_o     (pd)
    );

    increment #(.DATA_WIDTH(AW)) u_inc (
        .in_i  (pc_q),
        .out_o (pc_inc)
    );

    assign wentry = {pc_q, cache_data_i, pd.bj_op, pd.imm_src};

    fetch_queue #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH)) u_fq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (branching_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (rentry),
        .valid_o (valid_o),
        .level_o (level_o)
    );

    assign {pc_o, instr_o, branch_jump_op_o, imm_src_o} = rentry;

    // Next PC: redirect wins, otherwise advance only when a fetched word is accepted
    always_comb begin
        pc_d = pc_q;
        if (branching_i) pc_d = branch_target_i;
        else if (push)   pc_d = pc_inc;
    end

    // PC register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pc_q <= RESET_VECTOR[ADDR_WIDTH-1:2];
        else       pc_q <= pc_d;
    end

    assign cache_address_o = pc_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: reference queue model as scoreboard plus directed corner sequences.
module tb_instruction_fetch_unit;
    logic        clk = 0;
    logic        rst = 0;
    logic [29:0] addr, tgt, pc_o;
    logic        req, hit, stall, br, valid;
    logic [31:0] data, instr;
    logic [1:0]  bj;
    logic [2:0]  imm, level;

    // Narrow-address instance for the PC wrap case
    logic [5:0]  addr8, tgt8, pc8;
    logic        req8, br8, valid8;
    logic [31:0] instr8;
    logic [1:0]  bj8;
    logic [2:0]  imm8, level8;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ADDR_WIDTH(32), .QUEUE_DEPTH(4), .RESET_VECTOR(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .cache_address_o(addr), .cache_req_o(req),
        .cache_data_i(data), .cache_blocking_n_i(hit), .stall_i(stall),
        .branching_i(br), .branch_target_i(tgt), .valid_o(valid), .pc_o(pc_o),
        .instr_o(instr), .branch_jump_op_o(bj), .imm_src_o(imm), .level_o(level));

    instruction_fetch_unit #(.ADDR_WIDTH(8), .QUEUE_DEPTH(4), .RESET_VECTOR(32'h24)) dut8 (
        .clk_i(clk), .rst_i(rst), .cache_address_o(addr8), .cache_req_o(req8),
        .cache_data_i(32'h0000_0013), .cache_blocking_n_i(1'b1), .stall_i(1'b0),
        .branching_i(br8), .branch_target_i(tgt8), .valid_o(valid8), .pc_o(pc8),
        .instr_o(instr8), .branch_jump_op_o(bj8), .imm_src_o(imm8), .level_o(level8));

    typedef struct {
        logic [6:0] op;
        logic [1:0] bj;
        logic [2:0] imm;
    } vec_t;

    typedef struct {
        logic [29:0] pc;
        logic [31:0] instr;
        logic [1:0]  bj;
        logic [2:0]  imm;
    } exp_t;

    vec_t        tbl [8];
    exp_t        m_q [$];
    logic [29:0] m_pc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkdata(input logic [29:0] p);
        return {p[24:0], tbl[p[2:0]].op};
    endfunction

    // One cycle: drive after the falling edge, check mid-low phase, advance the model
    task automatic step(input logic h, input logic s, input logic b, input logic [29:0] t);
        exp_t e;
        logic pop_e, req_e, push_e;
        @(negedge clk);
        hit = h; stall = s; br = b; tgt = t; data = mkdata(m_pc);
        #1;
        pop_e  = (m_q.size() != 0) && !s;
        req_e  = !b && ((m_q.size() < 4) || pop_e);
        push_e = req_e && h;
        chk("cache_address", 64'(addr), 64'(m_pc));
        chk("cache_req", 64'(req), 64'(req_e));
        chk("level", 64'(level), 64'(m_q.size()));
        chk("valid", 64'(valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            e = m_q[0];
            chk("head_pc", 64'(pc_o), 64'(e.pc));
            chk("head_instr", 64'(instr), 64'(e.instr));
            chk("head_bj", 64'(bj), 64'(e.bj));
            chk("head_imm", 64'(imm), 64'(e.imm));
        end else begin
            chk("empty_head", {pc_o, instr, bj, imm}, 64'h0);
        end
        if (pop_e) void'(m_q.pop_front());
        if (b) begin
            m_q.delete();
            m_pc = t;
        end else if (push_e) begin
            e.pc = m_pc; e.instr = data;
            e.bj = tbl[m_pc[2:0]].bj; e.imm = tbl[m_pc[2:0]].imm;
            m_q.push_back(e);
            m_pc = m_pc + 30'd1;
        end
    endtask

    initial begin
        tbl[0] = '{7'b1100011, 2'b01, 3'b011};  // branch
        tbl[1] = '{7'b1101111, 2'b10, 3'b101};  // jal
        tbl[2] = '{7'b1100111, 2'b11, 3'b001};  // jalr
        tbl[3] = '{7'b0000011, 2'b00, 3'b001};  // load
        tbl[4] = '{7'b0100011, 2'b00, 3'b010};  // store
        tbl[5] = '{7'b0110111, 2'b00, 3'b100};  // lui
        tbl[6] = '{7'b0110011, 2'b00, 3'b000};  // op
        tbl[7] = '{7'b0010011, 2'b00, 3'b001};  // op-imm

        hit = 0; stall = 0; br = 0; tgt = '0; data = '0;
        br8 = 1; tgt8 = 6'h3E;

        // Reset asserted between edges: outputs clear at once
        #1 rst = 1;
        #2;
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_head", {pc_o, instr, bj, imm}, 64'h0);
        chk("rst_addr", 64'(addr), 64'h0);
        chk("rst_addr8", 64'(addr8), 64'h09);
        m_pc = '0;
        @(negedge clk) rst = 0;

        // Streaming
        repeat (8) step(1, 0, 0, '0);

        // Mid-operation reset
        @(negedge clk);
        hit = 0;
        #2 rst = 1;
        #1;
        chk("midrst_level", 64'(level), 64'h0);
        chk("midrst_valid", 64'(valid), 64'h0);
        chk("midrst_addr", 64'(addr), 64'h0);
        m_q.delete(); m_pc = '0;
        @(negedge clk) rst = 0;

        // Miss at PC=5
        repeat (5) step(1, 0, 0, '0);
        repeat (3) step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        chk("miss_resume_addr", 64'(addr), 64'h6);

        // Back-pressure to full
        repeat (7) step(1, 1, 0, '0);
        chk("full_level", 64'(level), 64'h4);
        chk("full_req", 64'(req), 64'h0);
        repeat (8) step(1, 0, 0, '0);
        repeat (6) step(0, 0, 0, '0);

        // Redirect with three queued entries
        repeat (3) step(1, 1, 0, '0);
        step(1, 0, 1, 30'h40);
        step(1, 0, 0, '0);
        chk("redir_addr", 64'(addr), 64'h40);
        chk("redir_level", 64'(level), 64'h0);
        repeat (3) step(1, 0, 0, '0);

        // Redirect while full and stalled
        repeat (6) step(1, 1, 0, '0);
        step(1, 1, 1, 30'h80);
        step(1, 0, 0, '0);
        chk("redir2_valid", 64'(valid), 64'h0);
        repeat (4) step(1, 0, 0, '0);
        repeat (4) step(0, 0, 0, '0);

        // PC wrap on the 6-bit word address
        @(negedge clk) br8 = 0;
        #1;
        chk("wrap_addr0", 64'(addr8), 64'h3E);
        chk("wrap_valid0", 64'(valid8), 64'h0);
        @(negedge clk) #1;
        chk("wrap_addr1", 64'(addr8), 64'h3F);
        chk("wrap_pc1", 64'(pc8), 64'h3E);
        @(negedge clk) #1;
        chk("wrap_addr2", 64'(addr8), 64'h00);
        chk("wrap_pc2", 64'(pc8), 64'h3F);
        @(negedge clk) #1;
        chk("wrap_pc3", 64'(pc8), 64'h00);
        chk("wrap_addr3", 64'(addr8), 64'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
